// File: rtl/alu_seq_pkg.sv
// Shared definitions for the EX-stage ALU sequencer: ex codes, ALU opcodes, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alu_seq_pkg;

    // ex operation codes as delivered by ID/EX
    localparam logic [2:0] EX_ADD   = 3'd0;
    localparam logic [2:0] EX_SUB   = 3'd1;
    localparam logic [2:0] EX_AND   = 3'd2;
    localparam logic [2:0] EX_OR    = 3'd3;
    localparam logic [2:0] EX_ADD_I = 3'd4;
    localparam logic [2:0] EX_SLT_I = 3'd5;
    localparam logic [2:0] EX_OR_I  = 3'd6;
    localparam logic [2:0] EX_XOR_I = 3'd7;

    // opcodes understood by the shared combinational ALU
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/alu_op_dec.sv
// Maps a 3-bit ex code onto the ALU opcode; also used by the forwarding logic.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of ex.
// Ports: ex (in, 3) operation code; alu_op (out, 3) ALU opcode.
module alu_op_dec
    import alu_seq_pkg::*;
(
    input  logic [2:0] ex,
    output logic [2:0] alu_op
);

    always_comb begin
        alu_op = ALU_ADD;
        case (ex)
            EX_ADD,
            EX_ADD_I: alu_op = ALU_ADD;
            EX_SUB:   alu_op = ALU_SUB;
            EX_AND:   alu_op = ALU_AND;
            EX_OR,
            EX_OR_I:  alu_op = ALU_OR;
            EX_XOR_I: alu_op = ALU_XOR;
            EX_SLT_I: alu_op = ALU_SLT;
            default:  alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// EX-stage sequencer: drives the shared ALU for single ops, runs shift-add for MUL.
// Latency: 2 cycles for ALU ops, WIDTH+1 cycles for MUL (1 cycle when MUL is not built).
// Backpressure: one op in flight; in_ready low until DONE is consumed by out_ready or flushed.
// Build option: define ALU_SEQ_MUL_EN to build the multiplier; otherwise is_mul returns err=1, result=0.
// Ports: clk/rst_n; in_valid/in_ready/ex/is_mul/a/b from ID/EX; flush; alu_op/alu_a/alu_b/alu_res
//        to/from the ALU; out_valid/out_ready/result/err to EX/MEM; busy to the hazard unit.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ex,
    input  logic             is_mul,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_res,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             err,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             err_q, err_d;
    logic [2:0]       dec_op;

    alu_op_dec u_dec (
        .ex     (ex),
        .alu_op (dec_op)
    );

`ifdef ALU_SEQ_MUL_EN
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mc_q, mc_d;
    logic [WIDTH-1:0] mp_q, mp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_sum;

    // accumulator after this cycle's partial product; also the final product on the last step
    assign acc_sum = mp_q[0] ? (acc_q + mc_q) : acc_q;
`endif

    always_comb begin
        state_d  = state_q;
        alu_op_d = alu_op_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        result_d = result_q;
        err_d    = err_q;
`ifdef ALU_SEQ_MUL_EN
        acc_d    = acc_q;
        mc_d     = mc_q;
        mp_d     = mp_q;
        cnt_d    = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // flush wins over a simultaneous offer, which is then not taken
                if (!flush && in_valid) begin
                    alu_a_d = a;
                    alu_b_d = b;
                    err_d   = 1'b0;
                    if (is_mul) begin
`ifdef ALU_SEQ_MUL_EN
                        acc_d   = '0;
                        mc_d    = a;
                        mp_d    = b;
                        cnt_d   = '0;
                        state_d = ST_MUL;
`else
                        result_d = '0;
                        err_d    = 1'b1;
                        state_d  = ST_DONE;
`endif
                    end else begin
                        alu_op_d = dec_op;
                        state_d  = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    result_d = alu_res;
                    state_d  = ST_DONE;
                end
            end
            ST_MUL: begin
`ifdef ALU_SEQ_MUL_EN
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = acc_sum;
                    mc_d  = mc_q << 1;
                    mp_d  = mp_q >> 1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_ITER) begin
                        result_d = acc_sum;
                        state_d  = ST_DONE;
                    end
                end
`else
                // unreachable without the multiplier; recover to IDLE
                state_d = ST_IDLE;
`endif
            end
            ST_DONE: begin
                if (flush || out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            alu_op_q <= ALU_ADD;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            acc_q    <= '0;
            mc_q     <= '0;
            mp_q     <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            alu_op_q <= alu_op_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            result_q <= result_d;
            err_q    <= err_d;
`ifdef ALU_SEQ_MUL_EN
            acc_q    <= acc_d;
            mc_q     <= mc_d;
            mp_q     <= mp_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign result    = result_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: random and directed ops against a behavioural reference.
// Latency: checked per op against the expected cycle count.
// Backpressure: out_ready held low for a random number of cycles in DONE.
module tb_alu_seq_ctrl;

    localparam int W = 32;
`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    // expected ALU opcode for each ex code 0..7
    localparam logic [2:0] OP_TAB [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd5, 3'd3, 3'd4};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   ex = 3'd0;
    logic         is_mul = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         flush = 1'b0;
    logic [2:0]   alu_op;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_res;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         err;
    logic         busy;

    int           n_tot = 0;
    int           n_bad = 0;
    logic [2:0]   exp_op = 3'd0;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ex        (ex),
        .is_mul    (is_mul),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_res   (alu_res),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .err       (err),
        .busy      (busy)
    );

    // the shared ALU the sequencer drives
    always_comb begin
        alu_res = '0;
        case (alu_op)
            3'b000: alu_res = alu_a + alu_b;
            3'b001: alu_res = alu_a - alu_b;
            3'b010: alu_res = alu_a & alu_b;
            3'b011: alu_res = alu_a | alu_b;
            3'b100: alu_res = alu_a ^ alu_b;
            3'b101: alu_res = W'($signed(alu_a) < $signed(alu_b));
            default: alu_res = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // architectural result of the operation, straight from the instruction semantics
    function automatic logic [W-1:0] ref_res(input logic m, input logic [2:0] e,
                                             input logic [W-1:0] x, input logic [W-1:0] y);
        if (m) return MUL_EN ? W'(x * y) : '0;
        case (e)
            3'd0, 3'd4: return x + y;
            3'd1:       return x - y;
            3'd2:       return x & y;
            3'd3, 3'd6: return x | y;
            3'd5:       return W'($signed(x) < $signed(y));
            default:    return x ^ y;
        endcase
    endfunction

    task automatic run_op(input logic m, input logic [2:0] e, input logic [W-1:0] x,
                          input logic [W-1:0] y, input int hold);
        int           lat;
        int           exp_lat;
        logic [W-1:0] er;
        logic         ee;
        er      = ref_res(m, e, x, y);
        ee      = m && !MUL_EN;
        exp_lat = !m ? 2 : (MUL_EN ? W + 1 : 1);
        if (!m) exp_op = OP_TAB[e];
        in_valid = 1'b1; is_mul = m; ex = e; a = x; b = y;
        @(posedge clk); #1;
        // scramble the inputs: the block must work from its captured copies
        in_valid = 1'b0; is_mul = 1'b0; ex = 3'($urandom); a = $urandom; b = $urandom;
        lat = 1;
        chk("accept_busy", {in_ready, busy}, 2'b01);
        if (!m) begin
            chk("alu_op_n1", alu_op, exp_op);
            chk("alu_ab_n1", {alu_a, alu_b}, {x, y});
        end
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("result", result, er);
        chk("err", err, ee);
        chk("alu_op_hold", alu_op, exp_op);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("bp_stable", {out_valid, in_ready, err, result}, {1'b1, 1'b0, ee, er});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("back_idle", {in_ready, busy, out_valid}, 3'b100);
    endtask

    task automatic accept_then_wait(input logic m, input int cycles);
        in_valid = 1'b1; is_mul = m; ex = 3'd0; a = 32'd5; b = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0; is_mul = 1'b0;
        if (!m) exp_op = 3'd0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctl", {in_ready, busy, out_valid, err}, 4'b1000);
        chk("rst_dat", {alu_op, alu_a, alu_b, result}, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_ctl", {in_ready, busy, out_valid, alu_op}, {3'b100, 3'd0});

        // SUB 10-3
        run_op(1'b0, 3'd1, 32'd10, 32'd3, 0);

        // decode sweep
        for (int e = 0; e < 8; e++) begin
            run_op(1'b0, 3'(e), $urandom, $urandom, 0);
        end

        // multiplies, second one under backpressure
        run_op(1'b1, 3'd0, 32'hFFFF_FFFF, 32'd3, 0);
        run_op(1'b1, 3'd0, 32'd1234, 32'd5678, 5);

        // ALU op under 5 cycles of backpressure
        run_op(1'b0, 3'd3, 32'h00F0_0F00, 32'h0000_00FF, 5);

        // flush at multiply iteration 10, then a normal ADD
        accept_then_wait(1'b1, 9);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_mul", {in_ready, busy, out_valid}, 3'b100);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("flush_mul_quiet", {out_valid, busy}, 2'b00);
        end
        run_op(1'b0, 3'd0, 32'd1, 32'd2, 0);

        // flush in EXEC
        accept_then_wait(1'b0, 0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_exec", {in_ready, busy, out_valid}, 3'b100);

        // flush in DONE while backpressured
        accept_then_wait(1'b0, 1);
        chk("done_before_flush", out_valid, 1'b1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_done", {in_ready, busy, out_valid}, 3'b100);

        // flush beats a simultaneous offer in IDLE
        in_valid = 1'b1; flush = 1'b1; is_mul = 1'b0; ex = 3'd1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_idle", {in_ready, busy, out_valid}, 3'b100);

        // asynchronous reset in the middle of an operation
        accept_then_wait(1'b1, 4);
        rst_n = 1'b0;
        #2;
        exp_op = 3'd0;
        chk("rst_mid", {in_ready, busy, out_valid, err, alu_op}, {4'b1000, 3'd0});
        chk("rst_mid_res", result, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // random traffic
        for (int n = 0; n < 40; n++) begin
            run_op(($urandom_range(0, 3) == 0), 3'($urandom), $urandom, $urandom,
                   $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
